// File: rtl/dispatch_ctrl_pkg.sv
// Shared constants and types for the dispatch controller and its instruction queue.
package dispatch_ctrl_pkg;

    // RV32I major opcodes seen by the dispatcher
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_B      = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int DATA_WIDTH = 32;
    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam logic  TRUE      = 1'b1;
    localparam logic  FALSE     = 1'b0;
    localparam data_t ZERO_WORD = '0;

    localparam int IQ_DEPTH_DEFAULT = 16;
    localparam int IQ_AW_DEFAULT    = 4;

    // Which back-end structure receives an instruction
    typedef enum logic [1:0] {
        UNIT_RS      = 2'd0,
        UNIT_LSB     = 2'd1,
        UNIT_ILLEGAL = 2'd2
    } unit_e;

    // One queue entry as handed over by the fetcher
    typedef struct packed {
        data_t instr;
        data_t pc;
        logic  jump_flag;
    } iq_entry_t;

    // Map a major opcode onto its target unit
    function automatic unit_e classify_opcode(input logic [6:0] opcode);
        unit_e unit;
        unique case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_B, OPC_OP_IMM, OPC_OP:               unit = UNIT_RS;
            OPC_LOAD, OPC_STORE:                     unit = UNIT_LSB;
            default:                                 unit = UNIT_ILLEGAL;
        endcase
        return unit;
    endfunction

endpackage

// File: rtl/dispatch_ctrl_instr_fifo.sv
// In-order circular instruction queue with push, pop and single-cycle flush.
import dispatch_ctrl_pkg::*;

module instr_fifo #(
    parameter int DEPTH = IQ_DEPTH_DEFAULT,
    parameter int AW    = IQ_AW_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  iq_entry_t   push_data,
    output iq_entry_t   head_data,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    iq_entry_t   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic        do_push;
    logic        do_pop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign head_data = mem[head];

    // Flush wins over everything; overflow and underflow requests are ignored
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Storage write; contents are don't-care after reset so no reset is applied
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping, with pointers wrapping naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: queues fetched instructions and hands the head to the
// decoder only when the ROB and the target reservation unit have room.
import dispatch_ctrl_pkg::*;

module dispatch_ctrl #(
    parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT,
    parameter int IQ_AW    = IQ_AW_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_fetcher_valid,
    input  logic [31:0] in_fetcher_instr,
    input  logic [31:0] in_fetcher_pc,
    input  logic        in_fetcher_jump_flag,
    output logic        out_fetcher_full,
    input  logic        in_rob_full,
    input  logic        in_rs_full,
    input  logic        in_lsb_full,
    input  logic        in_rollback,
    output logic [31:0] out_dec_instr,
    output logic [31:0] out_dec_pc,
    output logic        out_dec_jump_flag,
    output logic        out_dec_valid,
    output logic [31:0] out_stall_cnt
);

    iq_entry_t      push_data;
    iq_entry_t      head_data;
    logic           fifo_empty;
    logic           fifo_full;
    logic [IQ_AW:0] fifo_count;
    logic           push;
    logic           pop;
    logic           flush;
    unit_e          head_unit;
    logic           head_legal;
    logic           target_full;
    logic           active;
    logic           dispatch;
    logic           stall;

    assign push_data = '{instr: in_fetcher_instr, pc: in_fetcher_pc, jump_flag: in_fetcher_jump_flag};

    instr_fifo #(
        .DEPTH (IQ_DEPTH),
        .AW    (IQ_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (push_data),
        .head_data (head_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign out_fetcher_full = fifo_full;

    // Classify the head and pick the full flag of the unit it is bound for
    always_comb begin
        head_unit   = classify_opcode(head_data.instr[6:0]);
        head_legal  = (head_unit != UNIT_ILLEGAL);
        target_full = FALSE;
        case (head_unit)
            UNIT_RS:  target_full = in_rs_full;
            UNIT_LSB: target_full = in_lsb_full;
            default:  target_full = FALSE;
        endcase
    end

    // A cycle counts only when the core is running, not flushing, and has a head
    assign active   = rdy && !in_rollback && !fifo_empty;
    assign dispatch = active && head_legal && !in_rob_full && !target_full;
    assign stall    = active && head_legal && (in_rob_full || target_full);

    // Illegal heads are discarded without going to the decoder
    assign pop   = dispatch || (active && !head_legal);
    assign push  = in_fetcher_valid && !fifo_full && !in_rollback && rdy;
    assign flush = in_rollback && rdy;

    // Decoder sees the head only on a real dispatch, otherwise an all-zero bubble
    always_comb begin
        out_dec_valid     = FALSE;
        out_dec_instr     = ZERO_WORD;
        out_dec_pc        = ZERO_WORD;
        out_dec_jump_flag = FALSE;
        if (dispatch) begin
            out_dec_valid     = TRUE;
            out_dec_instr     = head_data.instr;
            out_dec_pc        = head_data.pc;
            out_dec_jump_flag = head_data.jump_flag;
        end
    end

    // Count cycles where a legal head is held back by back-pressure; survives rollback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_stall_cnt <= '0;
        end else if (stall) begin
            out_stall_cnt <= out_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based reference model.
module tb_dispatch_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_fetcher_valid;
    logic [31:0] in_fetcher_instr;
    logic [31:0] in_fetcher_pc;
    logic        in_fetcher_jump_flag;
    logic        out_fetcher_full;
    logic        in_rob_full;
    logic        in_rs_full;
    logic        in_lsb_full;
    logic        in_rollback;
    logic [31:0] out_dec_instr;
    logic [31:0] out_dec_pc;
    logic        out_dec_jump_flag;
    logic        out_dec_valid;
    logic [31:0] out_stall_cnt;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        jf;
    } model_entry_t;

    model_entry_t modelQ[$];
    logic [31:0]  modelStall;
    int           checks;
    int           failures;
    logic [31:0]  nextPc;

    always #5 clk = ~clk;

    dispatch_ctrl #(
        .IQ_DEPTH (16),
        .IQ_AW    (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rdy                  (rdy),
        .in_fetcher_valid     (in_fetcher_valid),
        .in_fetcher_instr     (in_fetcher_instr),
        .in_fetcher_pc        (in_fetcher_pc),
        .in_fetcher_jump_flag (in_fetcher_jump_flag),
        .out_fetcher_full     (out_fetcher_full),
        .in_rob_full          (in_rob_full),
        .in_rs_full           (in_rs_full),
        .in_lsb_full          (in_lsb_full),
        .in_rollback          (in_rollback),
        .out_dec_instr        (out_dec_instr),
        .out_dec_pc           (out_dec_pc),
        .out_dec_jump_flag    (out_dec_jump_flag),
        .out_dec_valid        (out_dec_valid),
        .out_stall_cnt        (out_stall_cnt)
    );

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // 0 = illegal, 1 = RS, 2 = LSB, straight from the opcode lists
    function automatic int unitOf(input logic [6:0] op);
        logic [6:0] rsOps [7];
        logic [6:0] lsbOps [2];
        rsOps  = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0010011, 7'b0110011};
        lsbOps = '{7'b0000011, 7'b0100011};
        foreach (rsOps[i])  if (rsOps[i] == op)  return 1;
        foreach (lsbOps[i]) if (lsbOps[i] == op) return 2;
        return 0;
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic jf, input logic rob, input logic rs, input logic lsb,
                                 input logic rb, input logic r);
        int           u;
        logic         expDisp;
        logic         wasFull;
        model_entry_t h;
        model_entry_t e;
        in_fetcher_valid     = v;
        in_fetcher_instr     = instr;
        in_fetcher_pc        = pc;
        in_fetcher_jump_flag = jf;
        in_rob_full          = rob;
        in_rs_full           = rs;
        in_lsb_full          = lsb;
        in_rollback          = rb;
        rdy                  = r;
        @(negedge clk);
        expDisp = 1'b0;
        h = '{instr: 32'h0, pc: 32'h0, jf: 1'b0};
        if (modelQ.size() > 0) begin
            h = modelQ[0];
            u = unitOf(h.instr[6:0]);
            if (r && !rb && !rob && ((u == 1 && !rs) || (u == 2 && !lsb))) expDisp = 1'b1;
        end
        checkOutput("fetcher_full", 32'(out_fetcher_full), 32'(modelQ.size() == DEPTH));
        checkOutput("dec_valid",    32'(out_dec_valid),    32'(expDisp));
        checkOutput("dec_instr",    out_dec_instr,         expDisp ? h.instr : 32'h0);
        checkOutput("dec_pc",       out_dec_pc,            expDisp ? h.pc : 32'h0);
        checkOutput("dec_jump",     32'(out_dec_jump_flag), expDisp ? 32'(h.jf) : 32'h0);
        checkOutput("stall_cnt",    out_stall_cnt,         modelStall);
        @(posedge clk);
        if (r) begin
            if (rb) begin
                modelQ.delete();
            end else begin
                wasFull = (modelQ.size() == DEPTH);
                if (modelQ.size() > 0) begin
                    u = unitOf(modelQ[0].instr[6:0]);
                    if (u == 0 || expDisp) void'(modelQ.pop_front());
                    else modelStall = modelStall + 32'd1;
                end
                if (v && !wasFull) begin
                    e = '{instr: instr, pc: pc, jf: jf};
                    modelQ.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic pushOne(input logic [31:0] instr, input logic rob, input logic rs, input logic lsb);
        applyStimulus(1'b1, instr, nextPc, nextPc[2], rob, rs, lsb, 1'b0, 1'b1);
        nextPc = nextPc + 32'd4;
    endtask

    task automatic idle(input int n, input logic rob, input logic rs, input logic lsb);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, rob, rs, lsb, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] randomInstr();
        logic [6:0] ops [9];
        logic [31:0] w;
        int k;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011};
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) w[6:0] = ops[k];
        return w;
    endfunction

    initial begin
        checks     = 0;
        failures   = 0;
        modelStall = 32'd0;
        nextPc     = 32'h0;
        rst = 1'b0; rdy = 1'b1; in_fetcher_valid = 1'b0; in_fetcher_instr = 32'h0;
        in_fetcher_pc = 32'h0; in_fetcher_jump_flag = 1'b0; in_rob_full = 1'b0;
        in_rs_full = 1'b0; in_lsb_full = 1'b0; in_rollback = 1'b0;
        #12;
        checkOutput("reset_full",  32'(out_fetcher_full), 32'h0);
        checkOutput("reset_valid", 32'(out_dec_valid),    32'h0);
        checkOutput("reset_instr", out_dec_instr,         32'h0);
        checkOutput("reset_stall", out_stall_cnt,         32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] single dispatch");
        applyStimulus(1'b1, 32'h00100093, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0, 1'b0, 1'b0);

        $display("[TB] LSB stall");
        pushOne(32'h0000A103, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b0, 1'b0, 1'b1);
        checkOutput("lsb_stall_cnt", out_stall_cnt, 32'd3);
        idle(2, 1'b0, 1'b0, 1'b0);

        $display("[TB] RS instruction under LSB full");
        pushOne(32'h002081B3, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0, 1'b0, 1'b1);

        $display("[TB] full queue and wrap");
        for (int i = 0; i < 17; i++) pushOne(32'h00100093 + (i << 20), 1'b1, 1'b0, 1'b0);
        checkOutput("full_flag", 32'(out_fetcher_full), 32'h1);
        idle(18, 1'b0, 1'b0, 1'b0);

        $display("[TB] rollback");
        for (int i = 0; i < 5; i++) pushOne(32'h0000A103, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00100093, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b0, 1'b0, 1'b0);

        $display("[TB] illegal head");
        pushOne(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        pushOne(32'h00100093, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0, 1'b0);

        $display("[TB] async reset mid-operation");
        for (int i = 0; i < 3; i++) pushOne(32'h002081B3, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        modelQ.delete();
        modelStall = 32'd0;
        checkOutput("arst_full",  32'(out_fetcher_full), 32'h0);
        checkOutput("arst_valid", 32'(out_dec_valid),    32'h0);
        checkOutput("arst_stall", out_stall_cnt,         32'h0);
        in_rob_full = 1'b0;
        #1;
        checkOutput("arst_instr", out_dec_instr, 32'h0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        idle(1, 1'b0, 1'b0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 9) < 6), randomInstr(), $urandom, 1'($urandom),
                          ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
                          ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 3),
                          ($urandom_range(0, 9) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
